// File: rtl/des_ahb_pkg.sv
// Shared AHB-Lite constants, DES slave register offsets and master FSM states.
package des_ahb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    W_MODE,
    W_KEY1,
    W_KEY2,
    W_KEY3,
    W_DATA,
    W_LAST,
    WAIT,
    R_ADDR,
    R_DATA,
    ERR
  } state_t;

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

  localparam logic [31:0] OFS_MODE = 32'h0000_0000;
  localparam logic [31:0] OFS_KEY1 = 32'h0000_0400;
  localparam logic [31:0] OFS_KEY2 = 32'h0000_0800;
  localparam logic [31:0] OFS_KEY3 = 32'h0000_0C00;
  localparam logic [31:0] OFS_DATA = 32'h0000_1000;

  localparam logic [2:0]  HSIZE_DWORD   = 3'b011;
  localparam logic [2:0]  HBURST_SINGLE = 3'b000;
  localparam logic [3:0]  HPROT_DEFAULT = 4'h3;

endpackage

// File: rtl/des_wait_counter.sv
// 10-bit load/decrement counter timing the DES processing gap before the result read.
module des_wait_counter (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       load,
  input  logic [9:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [9:0] count_reg;

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != 10'd0)) begin
      count_reg <= count_reg - 10'd1;
    end
  end

  assign zero = (count_reg == 10'd0);

endmodule

// File: rtl/ahb_lite_des_master.sv
// AHB-Lite master that loads mode/keys/data into the Triple DES slave and reads the result back.
// Optional key reuse (skips rewriting unchanged keys) is enabled by defining DES_MASTER_KEY_CACHE_EN.
import des_ahb_pkg::*;

module ahb_lite_des_master #(
  parameter int          PROC_CYCLES = 50,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic        encryptionTypeIn,
  input  logic [63:0] keyIn1,
  input  logic [63:0] keyIn2,
  input  logic [63:0] keyIn3,
  input  logic [63:0] dataIn,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [63:0] result,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [63:0] HWDATA,
  input  logic [63:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [9:0] WAIT_LOAD = 10'(PROC_CYCLES - 1);

  state_t      state_reg, state_next;
  logic        enc_reg;
  logic [63:0] key1_reg, key2_reg, key3_reg, data_reg;
  logic [63:0] hwdata_reg, result_reg;
  logic        done_reg;

  logic        addr_phase, write_phase;
  logic [31:0] addr_ofs;
  logic [63:0] wdata_cur;
  logic        cnt_load, cnt_dec, cnt_zero;
  logic        accept, complete, bus_err, cache_hit;

  assign bus_err = HREADY && HRESP && (state_reg != IDLE) && (state_reg != ERR);

  always_comb begin
    state_next  = state_reg;
    addr_phase  = 1'b0;
    write_phase = 1'b0;
    addr_ofs    = OFS_MODE;
    wdata_cur   = '0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    accept      = 1'b0;
    complete    = 1'b0;
    case (state_reg)
      IDLE, ERR: begin
        if (start) begin
          accept     = 1'b1;
          state_next = W_MODE;
        end
      end
      W_MODE: begin
        addr_phase  = 1'b1;
        write_phase = 1'b1;
        addr_ofs    = OFS_MODE;
        wdata_cur   = {63'd0, enc_reg};
        if (HREADY) state_next = cache_hit ? W_DATA : W_KEY1;
      end
      W_KEY1: begin
        addr_phase  = 1'b1;
        write_phase = 1'b1;
        addr_ofs    = OFS_KEY1;
        wdata_cur   = key1_reg;
        if (HREADY) state_next = W_KEY2;
      end
      W_KEY2: begin
        addr_phase  = 1'b1;
        write_phase = 1'b1;
        addr_ofs    = OFS_KEY2;
        wdata_cur   = key2_reg;
        if (HREADY) state_next = W_KEY3;
      end
      W_KEY3: begin
        addr_phase  = 1'b1;
        write_phase = 1'b1;
        addr_ofs    = OFS_KEY3;
        wdata_cur   = key3_reg;
        if (HREADY) state_next = W_DATA;
      end
      W_DATA: begin
        addr_phase  = 1'b1;
        write_phase = 1'b1;
        addr_ofs    = OFS_DATA;
        wdata_cur   = data_reg;
        if (HREADY) state_next = W_LAST;
      end
      W_LAST: begin
        if (HREADY) begin
          cnt_load   = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_zero) state_next = R_ADDR;
        else          cnt_dec    = 1'b1;
      end
      R_ADDR: begin
        addr_phase = 1'b1;
        addr_ofs   = OFS_DATA;
        if (HREADY) state_next = R_DATA;
      end
      R_DATA: begin
        if (HREADY) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A bus error overrides whatever progress this cycle would have made.
    if (bus_err) begin
      state_next = ERR;
      complete   = 1'b0;
      cnt_load   = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_reg  <= IDLE;
      enc_reg    <= 1'b0;
      key1_reg   <= '0;
      key2_reg   <= '0;
      key3_reg   <= '0;
      data_reg   <= '0;
      hwdata_reg <= '0;
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= complete;
      if (accept) begin
        enc_reg  <= encryptionTypeIn;
        key1_reg <= keyIn1;
        key2_reg <= keyIn2;
        key3_reg <= keyIn3;
        data_reg <= dataIn;
      end
      // Write data follows its address phase by one accepted cycle.
      if (write_phase && HREADY && !HRESP) hwdata_reg <= wdata_cur;
      if (complete) result_reg <= HRDATA;
    end
  end

`ifdef DES_MASTER_KEY_CACHE_EN
  logic        cache_valid_reg;
  logic [63:0] ckey1_reg, ckey2_reg, ckey3_reg;

  assign cache_hit = cache_valid_reg && (key1_reg == ckey1_reg) &&
                     (key2_reg == ckey2_reg) && (key3_reg == ckey3_reg);

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      cache_valid_reg <= 1'b0;
      ckey1_reg       <= '0;
      ckey2_reg       <= '0;
      ckey3_reg       <= '0;
    end else if (bus_err) begin
      cache_valid_reg <= 1'b0;
    end else if (complete) begin
      cache_valid_reg <= 1'b1;
      ckey1_reg       <= key1_reg;
      ckey2_reg       <= key2_reg;
      ckey3_reg       <= key3_reg;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  des_wait_counter u_wait_counter (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign HTRANS    = addr_phase ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = addr_phase ? (BASE_ADDR + addr_ofs) : 32'd0;
  assign HWRITE    = write_phase;
  assign HWDATA    = hwdata_reg;
  assign HSIZE     = HSIZE_DWORD;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_DEFAULT;
  assign HMASTLOCK = 1'b0;
  assign busy      = (state_reg != IDLE) && (state_reg != ERR);
  assign error     = (state_reg == ERR);
  assign done      = done_reg;
  assign result    = result_reg;

endmodule

// File: doc/ahb_lite_des_master.md
Name: ahb_lite_des_master

Overview:
AHB-Lite initiator that drives the Triple DES slave's register map from a simple local command port.
- On a start pulse it writes mode, key1, key2, key3 and data as single 64-bit NONSEQ transfers.
- It then waits a fixed processing time and reads the 64-bit result back.
- Sits between the host-side/test logic and the DES slave; it is the only master on the slave's bus.

Parameters:
- PROC_CYCLES, 50, idle cycles between the data-write data phase and the result-read address phase (range 1..1023).
- BASE_ADDR, 32'h0000_0000, base added to every register offset.

Ports:
- HCLK  in  1  bus clock
- HRESET  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe; ignored while busy=1
- encryptionTypeIn  in  1  written to mode register bit 0 (other bits 0)
- keyIn1 / keyIn2 / keyIn3  in  64 each  keys
- dataIn  in  64  plaintext/ciphertext block
- busy  out  1  high from the cycle after an accepted start until done or error
- done  out  1  one-cycle pulse when result is valid
- error  out  1  high after a bus error; cleared by the next accepted start
- result  out  64  last read data; held until the next done
- HADDR  out  32  address
- HWRITE  out  1  write strobe
- HTRANS  out  2  2'b10 NONSEQ or 2'b00 IDLE only
- HSIZE  out  3  constant 3'b011
- HBURST  out  3  constant 3'b000
- HPROT  out  4  constant 4'h3
- HMASTLOCK  out  1  constant 0
- HWDATA  out  64  write data, data phase
- HRDATA  in  64  read data
- HREADY  in  1  transfer-complete / wait-state indicator
- HRESP  in  1  error response

Behaviour:
Offsets: mode 0x000, key1 0x400, key2 0x800, key3 0xC00, data/result 0x1000.

States: IDLE, W_MODE, W_KEY1, W_KEY2, W_KEY3, W_DATA, W_LAST, WAIT, R_ADDR, R_DATA, ERR.
- IDLE: HTRANS=IDLE. On start, latch all command inputs into internal registers and go to W_MODE.
- W_MODE..W_DATA are address phases.
  - Each drives HTRANS=NONSEQ, HWRITE=1 and HADDR = BASE_ADDR + offset.
  - HWDATA carries the previous state's value (pipelined data phase).
  - State advances only on a cycle with HREADY=1. With HREADY=0, HADDR, HTRANS, HWRITE and HWDATA hold.
- W_LAST: HTRANS=IDLE, HWDATA=data. On HREADY=1, go to WAIT and load the counter with PROC_CYCLES-1.
- WAIT: HTRANS=IDLE; decrement each cycle; go to R_ADDR at count 0.
- R_ADDR: NONSEQ read, HWRITE=0, HADDR = BASE_ADDR+0x1000. On HREADY=1, go to R_DATA.
- R_DATA: HTRANS=IDLE. On HREADY=1:
  - result <= HRDATA;
  - done=1 for exactly that cycle, registered so it is visible the following cycle;
  - busy drops with done; go to IDLE.
- Error, in any non-IDLE state: HRESP=1 sampled with HREADY=1 →
  - HTRANS=IDLE next cycle, go to ERR, error=1, busy=0, result unchanged.
- ERR: remain until start. A start in ERR clears error and proceeds exactly as a start from IDLE.
- start while busy=1: ignored, no effect on the transaction in flight.
- Reset, including mid-transfer: all outputs take reset values immediately and the state goes to IDLE.
  - Reset values: HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, error=0, result=0. The constant outputs are unaffected.
- Minimum latency with HREADY always 1: start to done is 8 + PROC_CYCLES cycles.

Optional Feature:
DES_MASTER_KEY_CACHE_EN.
- Defined:
  - Keep a copy of key1/2/3 from the last successfully completed operation, plus a valid bit. The valid bit is cleared by reset and by error.
  - If the valid bit is set and all three latched keys match the copy, W_MODE advances directly to W_DATA. HWDATA in the W_DATA address phase is then the mode value.
  - start-to-done shrinks by 3 cycles.
- Undefined: keys are always written.

Decomposition:
- Package des_ahb_pkg:
  - state enum;
  - HTRANS_IDLE / HTRANS_NONSEQ;
  - the register offset constants;
  - HSIZE/HBURST/HPROT constants, shared with the slave.
- Sub-module des_wait_counter: 10-bit load/decrement/zero flag for WAIT.

Test Plan:
- HREADY=1, encryptionTypeIn=1, keys 0x0123456789ABCDEF / 0x23456789ABCDEF01 / 0x456789ABCDEF0123, dataIn=0x4E6F772069732074.
  - Required: writes to 0x0, 0x400, 0x800, 0xC00, 0x1000 in order with matching HWDATA; read of 0x1000; result equals slave HRDATA; done at cycle 8+PROC_CYCLES.
- HREADY=0 for 3 cycles during the W_KEY2 address phase → HADDR stays 0x800 and HWDATA stays key1 while stalled; total latency +3.
- HRESP=1 during the key3 data phase → HTRANS=00 next cycle, error=1, busy=0, no done. A following start clears error and the transaction completes.
- start pulsed again at cycle 4 of an operation → ignored; exactly one done, transfer sequence unchanged.
- HRESET low during WAIT → all outputs at reset values in the same cycle. A new start after release completes normally.
- With DES_MASTER_KEY_CACHE_EN, two back-to-back operations with identical keys → the second issues only writes to 0x0 and 0x1000, and done arrives 3 cycles earlier.
